// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Items shared by the UART receiver and transmitter:
//   - uart_state_t : 2-bit frame state encoding (IDLE=00, START=01, DATA=10,
//                    STOP=11)
//   - BAUD_CNT_W   : width of the per-bit clock counter
//   - calc_div     : clocks per bit, CLK_FREQ/BAUD (integer division)
//   - calc_half    : clocks per half bit, used for mid-bit sampling
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_t;

  localparam int unsigned BAUD_CNT_W = 32'd16;

  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

  function automatic int unsigned calc_half(input int unsigned clk_freq,
                                            input int unsigned baud);
    return calc_div(clk_freq, baud) / 32'd2;
  endfunction

endpackage

// File: rtl/uart_sync2ff.sv
// -----------------------------------------------------------------------------
// uart_sync2ff
// Two-flop synchronizer for a single asynchronous input.
// Parameters:
//   RST_VAL : value both flops take while rst_n is low (idle level of d)
// Ports:
//   clk   in  1  sampling clock
//   rst_n in  1  asynchronous active-low reset
//   d     in  1  asynchronous input
//   q     out 1  input synchronised to clk (two cycles of latency)
// -----------------------------------------------------------------------------
module uart_sync2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage shift register; the first stage may go metastable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver. Detects a falling start edge, confirms it at mid start
// bit, samples eight data bits (LSB first) at mid-bit, then checks the stop bit.
// Parameters:
//   CLK_FREQ : system clock frequency in Hz
//   BAUD     : serial bit rate
// Ports:
//   clk       in  1  system clock, rising edge
//   rst_n     in  1  asynchronous active-low reset
//   rx        in  1  asynchronous serial line, idle high
//   rx_data   out 8  last correctly framed byte (held between strobes)
//   rx_valid  out 1  one-cycle strobe: rx_data updated
//   rx_busy   out 1  high from accepted start edge until back in IDLE
//   frame_err out 1  one-cycle strobe: stop bit sampled low
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 32'd50_000_000,
  parameter int unsigned BAUD     = 32'd115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err
);

  localparam int unsigned DIV  = calc_div(CLK_FREQ, BAUD);
  localparam int unsigned HALF = calc_half(CLK_FREQ, BAUD);
  localparam logic [BAUD_CNT_W-1:0] DIV_M1  = BAUD_CNT_W'(DIV - 32'd1);
  localparam logic [BAUD_CNT_W-1:0] HALF_M1 = BAUD_CNT_W'(HALF - 32'd1);

  logic                  rx_s;
  logic                  rx_q_r;
  uart_state_t           state_r,    state_nxt_s;
  logic [BAUD_CNT_W-1:0] baud_cnt_r, baud_cnt_nxt_s;
  logic [2:0]            bit_cnt_r,  bit_cnt_nxt_s;
  logic [7:0]            shift_r,    shift_nxt_s;
  logic [7:0]            data_r,     data_nxt_s;
  logic                  valid_r,    valid_nxt_s;
  logic                  ferr_r,     ferr_nxt_s;
  logic                  busy_r;

  uart_sync2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  // Delayed copy of the synchronised line for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q_r <= 1'b1;
    end else begin
      rx_q_r <= rx_s;
    end
  end

  // State register plus all datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      baud_cnt_r <= '0;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'h00;
      data_r     <= 8'h00;
      valid_r    <= 1'b0;
      ferr_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      baud_cnt_r <= baud_cnt_nxt_s;
      bit_cnt_r  <= bit_cnt_nxt_s;
      shift_r    <= shift_nxt_s;
      data_r     <= data_nxt_s;
      valid_r    <= valid_nxt_s;
      ferr_r     <= ferr_nxt_s;
      // Busy follows the state being entered so it falls together with
      // the return to IDLE and a new start edge can be taken next cycle.
      busy_r     <= (state_nxt_s != IDLE);
    end
  end

  // Next-state and datapath decode for the frame FSM.
  always_comb begin
    state_nxt_s    = state_r;
    baud_cnt_nxt_s = baud_cnt_r + {{(BAUD_CNT_W-1){1'b0}}, 1'b1};
    bit_cnt_nxt_s  = bit_cnt_r;
    shift_nxt_s    = shift_r;
    data_nxt_s     = data_r;
    valid_nxt_s    = 1'b0;
    ferr_nxt_s     = 1'b0;

    case (state_r)
      IDLE: begin
        baud_cnt_nxt_s = '0;
        // Only a fresh falling edge starts a frame; a line stuck low does not.
        if (rx_q_r && !rx_s) begin
          state_nxt_s   = START;
          bit_cnt_nxt_s = 3'd0;
        end else begin
          state_nxt_s   = IDLE;
        end
      end

      START: begin
        if (baud_cnt_r == HALF_M1) begin
          baud_cnt_nxt_s = '0;
          // Still low at mid start bit: real start. High: glitch, drop it.
          if (!rx_s) begin
            state_nxt_s = DATA;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = START;
        end
      end

      DATA: begin
        if (baud_cnt_r == DIV_M1) begin
          baud_cnt_nxt_s = '0;
          // LSB arrives first, so shift in at the top and move right.
          shift_nxt_s    = {rx_s, shift_r[7:1]};
          if (bit_cnt_r == 3'd7) begin
            bit_cnt_nxt_s = 3'd0;
            state_nxt_s   = STOP;
          end else begin
            bit_cnt_nxt_s = bit_cnt_r + 3'd1;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end

      STOP: begin
        if (baud_cnt_r == DIV_M1) begin
          baud_cnt_nxt_s = '0;
          state_nxt_s    = IDLE;
          if (rx_s) begin
            data_nxt_s  = shift_r;
            valid_nxt_s = 1'b1;
          end else begin
            ferr_nxt_s  = 1'b1;
          end
        end else begin
          state_nxt_s = STOP;
        end
      end

      default: begin
        state_nxt_s    = IDLE;
        baud_cnt_nxt_s = '0;
        bit_cnt_nxt_s  = 3'd0;
      end
    endcase
  end

  assign rx_data   = data_r;
  assign rx_valid  = valid_r;
  assign rx_busy   = busy_r;
  assign frame_err = ferr_r;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx at 1 MHz / 100 kbaud (10 clocks per bit).
// Expected strobes are queued when a frame is driven and checked by a
// monitor when rx_valid or frame_err appears.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int unsigned CLK_FREQ = 32'd1_000_000;
  localparam int unsigned BAUD     = 32'd100_000;
  localparam int          DIV      = 10;
  localparam int          HALF     = 5;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;

  int   vectors;
  int   miscompares;
  int   valid_cnt;
  int   ferr_cnt;
  exp_t exp_q[$];
  exp_t mon_e;
  logic prev_strobe;
  time  last_strobe_t;
  time  t0;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_busy   (rx_busy),
    .frame_err (frame_err)
  );

  // 100 MHz-equivalent bench clock (period 10 ns).
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (DIV) @(negedge clk);
  endtask

  // Serial 8N1 transmitter model (LSB first), stop bit level selectable.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_q.push_back('{is_err: 1'b0, data: b});
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    valid_cnt     = 0;
    ferr_cnt      = 0;
    prev_strobe   = 1'b0;
    last_strobe_t = 0;
    rx            = 1'b1;
    rst_n         = 1'b0;

    // Monitor: every strobe must be expected, exclusive and one cycle wide.
    fork
      forever begin
        @(negedge clk);
        if (rx_valid || frame_err) begin
          check("strobe_exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
          check("strobe_one_cycle", {31'd0, prev_strobe}, 32'd0);
          check("strobe_expected", {31'd0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("strobe_kind", {31'd0, frame_err}, {31'd0, mon_e.is_err});
            check("rx_data", {24'd0, rx_data}, {24'd0, mon_e.data});
          end
          last_strobe_t = $time;
          if (rx_valid)  valid_cnt++;
          if (frame_err) ferr_cnt++;
        end
        prev_strobe = rx_valid | frame_err;
      end
    join_none

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_rx_data",   {24'd0, rx_data},   32'd0);
    check("rst_rx_valid",  {31'd0, rx_valid},  32'd0);
    check("rst_rx_busy",   {31'd0, rx_busy},   32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 0xA5 good frame, with strobe timing: 2 sync flops + 1 edge cycle,
    // then HALF + 9*DIV clocks to the stop sample, strobe the next cycle.
    expect_byte(8'hA5);
    t0 = $time;
    send_byte(8'hA5, 1'b1);
    wait_drain(50);
    check("a5_latency", 32'(last_strobe_t - t0), 32'((3 + HALF + 9 * DIV) * 10));
    check("a5_busy_idle", {31'd0, rx_busy}, 32'd0);

    // Short low glitch: start accepted, rejected at mid start bit.
    rx = 1'b0;
    repeat (3) @(negedge clk);
    check("glitch_busy_hi", {31'd0, rx_busy}, 32'd1);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    check("glitch_busy_lo", {31'd0, rx_busy}, 32'd0);
    repeat (10) @(negedge clk);

    // 0x3C with low stop bit, then line held low: no new frame.
    exp_q.push_back('{is_err: 1'b1, data: 8'hA5});
    send_byte(8'h3C, 1'b0);
    wait_drain(50);
    repeat (40) @(negedge clk);
    check("ferr_hold_busy", {31'd0, rx_busy}, 32'd0);
    check("ferr_keep_data", {24'd0, rx_data}, 32'h0000_00A5);
    rx = 1'b1;
    repeat (20) @(negedge clk);

    // Back-to-back 0x00 then 0xFF with no idle gap.
    expect_byte(8'h00);
    expect_byte(8'hFF);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    wait_drain(50);
    check("b2b_data", {24'd0, rx_data}, 32'h0000_00FF);
    repeat (20) @(negedge clk);

    // Reset pulsed during bit 4 of 0x5A; partial byte must vanish.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(((8'h5A >> i) & 8'h01) != 8'h00);
    rx = 1'b1;
    repeat (HALF) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_busy", {31'd0, rx_busy}, 32'd0);
    check("midrst_data", {24'd0, rx_data}, 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    expect_byte(8'h81);
    send_byte(8'h81, 1'b1);
    wait_drain(50);
    check("midrst_81", {24'd0, rx_data}, 32'h0000_0081);
    repeat (20) @(negedge clk);

    // Loopback from transmitter model: every byte value back-to-back.
    for (int b = 0; b < 256; b++) begin
      expect_byte(8'(b));
      send_byte(8'(b), 1'b1);
    end
    wait_drain(50);
    check("loop_last_data", {24'd0, rx_data}, 32'h0000_00FF);
    check("total_valid", 32'(valid_cnt), 32'd260);
    check("total_ferr",  32'(ferr_cnt),  32'd1);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning serial bit rate.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port rx_data  output  8  last correctly framed byte.
REQ-007 SHALL have port rx_valid  output  1  one-cycle strobe: rx_data updated.
REQ-008 SHALL have port rx_busy  output  1  high from accepted start edge until return to IDLE.
REQ-009 SHALL have port frame_err  output  1  one-cycle strobe: stop bit sampled low.

Function
REQ-010 SHALL use DIV = CLK_FREQ/BAUD (integer division) and HALF = DIV/2; baud counter 16 bits, wide enough for DIV-1.
REQ-011 SHALL pass rx through a 2-flop synchronizer (reset value 1) to give rx_s; all decisions use rx_s only.
REQ-012 SHALL keep a registered copy rx_q of rx_s (reset 1) for edge detection.
REQ-013 SHALL implement states IDLE, START, DATA, STOP.
REQ-014 IDLE: on falling edge (rx_q=1, rx_s=0) SHALL go to START with baud_cnt=0, bit_cnt=0, rx_busy=1; a line held low without a fresh falling edge SHALL NOT start a frame.
REQ-015 START: at baud_cnt=HALF-1, SHALL sample rx_s; 0 -> DATA with baud_cnt=0; 1 -> IDLE (glitch reject), no strobe.
REQ-016 DATA: at baud_cnt=DIV-1, SHALL shift rx_s into shift register MSB (shift right, LSB first on line), reset baud_cnt; after the 8th sample -> STOP.
REQ-017 STOP: at baud_cnt=DIV-1, SHALL sample rx_s; 1 -> rx_data<=shift register, rx_valid=1 next cycle; 0 -> frame_err=1 next cycle, rx_data unchanged; both -> IDLE.
REQ-018 SHALL give latency: with falling edge seen at cycle T, bit i (0..7) sampled at T+HALF+(i+1)*DIV, stop at T+HALF+9*DIV, strobe at T+HALF+9*DIV+1.
REQ-019 rx_valid and frame_err SHALL never be high together and SHALL be high exactly one cycle per frame.
REQ-020 rx_data SHALL hold its value between rx_valid strobes; no consumer handshake, no overrun detection.
REQ-021 rx_busy SHALL drop in the cycle IDLE is re-entered, allowing a start edge to be accepted the following cycle (back-to-back frames).

Reset
REQ-022 rst_n low SHALL immediately force state=IDLE, counters=0, shift register=0, rx_data=8'h00, rx_valid=0, rx_busy=0, frame_err=0, synchronizer and rx_q=1.
REQ-023 Reset mid-frame SHALL discard the partial byte with no strobe; reception resumes on the next falling edge after release.

Structure
REQ-024 SHALL place the state encoding (2-bit, IDLE=00, START=01, DATA=10, STOP=11) and the DIV/HALF derivation in shared package uart_pkg, also used by the transmitter.
REQ-025 SHALL instantiate one sub-module, uart_sync2ff (2-flop synchronizer, reset value parameter), reusable elsewhere.

Verification (bench: CLK_FREQ=1_000_000, BAUD=100_000 -> DIV=10, HALF=5)
REQ-026 Serial 0xA5, 10 clocks/bit, stop high -> rx_data=8'hA5, rx_valid high exactly 1 cycle, frame_err=0.
REQ-027 rx low for 3 cycles then high -> no rx_valid, no frame_err, rx_busy back to 0 after START sample.
REQ-028 0x3C with stop bit low -> frame_err 1 cycle, rx_data keeps prior value, no rx_valid; line held low -> no new frame until high then low again.
REQ-029 Back-to-back 0x00 then 0xFF, zero idle gap -> two rx_valid strobes, rx_data 8'h00 then 8'hFF.
REQ-030 rst_n pulsed low during bit 4 of 0x5A, then 0x81 sent -> no strobe for 0x5A, rx_data=8'h81 after second frame.
REQ-031 Loopback from the team transmitter (same parameters), bytes 0x00..0xFF -> all 256 received in order, zero frame_err.
